fifo_drain: RTL



---
 rtl/fifo_drain.sv | 108 ++++++++++
 1 files changed

// File: rtl/fifo_drain.sv
// Read-side controller for the synchronous FIFO: issues reads, absorbs the registered
// read latency in a two-entry skid buffer, and presents words on a valid/ready stream.
// Optional delivered-word counter (pop_count) is enabled with FIFO_DRAIN_STATS_EN.
module fifo_drain #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [15:0]           pop_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                  occ_reg, occ_next;
    logic                  inflight_reg;
    logic [DATA_WIDTH-1:0] head_reg, tail_reg;

    logic       pop;
    logic [2:0] level;
    logic       head_from_fifo, tail_from_fifo, head_from_tail;

    assign m_valid = (occ_reg != EMPTY);
    assign m_data  = head_reg;
    assign pop     = m_valid && m_ready;

    // Words held after this cycle, before any new read; a read may only be
    // issued when this leaves room for the word to land next cycle.
    assign level      = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && (level <= 3'd1);

    always_comb begin
        occ_next = occ_reg;
        if (flush) begin
            occ_next = EMPTY;
        end else begin
            case (occ_reg)
                EMPTY: if (inflight_reg) occ_next = HALF;
                HALF: begin
                    if (inflight_reg && !pop)      occ_next = FULL;
                    else if (!inflight_reg && pop) occ_next = EMPTY;
                end
                FULL: if (pop && !inflight_reg) occ_next = HALF;
                default: occ_next = EMPTY;
            endcase
        end
    end

    // The arriving word lands at index occ - pop; a pop from FULL advances the tail.
    always_comb begin
        head_from_fifo = 1'b0;
        tail_from_fifo = 1'b0;
        head_from_tail = 1'b0;
        if (!flush) begin
            head_from_tail = pop && (occ_reg == FULL);
            if (inflight_reg) begin
                head_from_fifo = (occ_reg == EMPTY) || ((occ_reg == HALF) && pop);
                tail_from_fifo = ((occ_reg == HALF) && !pop) || ((occ_reg == FULL) && pop);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= EMPTY;
            inflight_reg <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (head_from_fifo)      head_reg <= fifo_data_out;
            else if (head_from_tail) head_reg <= tail_reg;
            if (tail_from_fifo)      tail_reg <= fifo_data_out;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    // Counts deliveries only; flush leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_count <= 16'd0;
        end else if (pop) begin
            pop_count <= pop_count + 16'd1;
        end
    end
`endif

endmodule
